main_fsm: RTL

MAIN_FSM -- requirements
Module: main_fsm

---
 rtl/main_fsm_pkg.sv | 57 +++++
 rtl/main_fsm_out_dec.sv | 79 +++++++
 rtl/main_fsm.sv | 78 +++++++
 3 files changed

// File: rtl/main_fsm_pkg.sv
// Shared types and constants for the multicycle main control FSM:
// state encoding, opcode values, mux selects and the decoded control word.
package main_fsm_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10
   } statetype_t;

   localparam logic [6:0] OP_LW     = 7'b0000011;
   localparam logic [6:0] OP_SW     = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [2:0] F3_BNE = 3'b001;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   typedef struct packed {
      logic       irwrite;
      logic       pcupdate;
      logic       branch;
      logic       adrsrc;
      logic       memwrite;
      logic       regwrite;
      logic [1:0] resultsrc;
      logic [1:0] alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
   } ctrl_t;

endpackage

// File: rtl/main_fsm_out_dec.sv
// Moore output decoder: maps the current state to the datapath control word.
// Unused state encodings decode to an all-zero word.
module main_fsm_out_dec
   import main_fsm_pkg::*;
(
   input  statetype_t state_i,
   output ctrl_t      ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      case (state_i)
         S_FETCH: begin
            ctrl_o.adrsrc    = 1'b0;
            ctrl_o.irwrite   = 1'b1;
            ctrl_o.alusrca   = SRCA_PC;
            ctrl_o.alusrcb   = SRCB_FOUR;
            ctrl_o.aluop     = ALUOP_ADD;
            ctrl_o.resultsrc = RES_ALURESULT;
            ctrl_o.pcupdate  = 1'b1;
         end
         // Branch target is precomputed here from OldPC + imm.
         S_DECODE: begin
            ctrl_o.alusrca = SRCA_OLDPC;
            ctrl_o.alusrcb = SRCB_IMM;
            ctrl_o.aluop   = ALUOP_ADD;
         end
         S_MEMADR: begin
            ctrl_o.alusrca = SRCA_RS1;
            ctrl_o.alusrcb = SRCB_IMM;
            ctrl_o.aluop   = ALUOP_ADD;
         end
         S_MEMREAD: begin
            ctrl_o.resultsrc = RES_ALUOUT;
            ctrl_o.adrsrc    = 1'b1;
         end
         S_MEMWB: begin
            ctrl_o.resultsrc = RES_DATA;
            ctrl_o.regwrite  = 1'b1;
         end
         S_MEMWRITE: begin
            ctrl_o.resultsrc = RES_ALUOUT;
            ctrl_o.adrsrc    = 1'b1;
            ctrl_o.memwrite  = 1'b1;
         end
         S_EXECUTER: begin
            ctrl_o.alusrca = SRCA_RS1;
            ctrl_o.alusrcb = SRCB_RS2;
            ctrl_o.aluop   = ALUOP_FUNCT;
         end
         S_EXECUTEI: begin
            ctrl_o.alusrca = SRCA_RS1;
            ctrl_o.alusrcb = SRCB_IMM;
            ctrl_o.aluop   = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            ctrl_o.resultsrc = RES_ALUOUT;
            ctrl_o.regwrite  = 1'b1;
         end
         S_BRANCH: begin
            ctrl_o.alusrca   = SRCA_RS1;
            ctrl_o.alusrcb   = SRCB_RS2;
            ctrl_o.aluop     = ALUOP_SUB;
            ctrl_o.resultsrc = RES_ALUOUT;
            ctrl_o.branch    = 1'b1;
         end
         // Link address (OldPC + 4) goes to ALUOut; target was computed in DECODE.
         S_JAL: begin
            ctrl_o.alusrca   = SRCA_OLDPC;
            ctrl_o.alusrcb   = SRCB_FOUR;
            ctrl_o.aluop     = ALUOP_ADD;
            ctrl_o.resultsrc = RES_ALUOUT;
            ctrl_o.pcupdate  = 1'b1;
         end
         default: ctrl_o = '0;
      endcase
   end

endmodule

// File: rtl/main_fsm.sv
// Multicycle RISC-V main control FSM: state register, next-state logic and
// branch-resolved PC write enable; per-state outputs come from main_fsm_out_dec.
module main_fsm
   import main_fsm_pkg::*;
#(
   parameter int BNE_EN = 1
)(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       zero,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [3:0] state_o
);

   statetype_t state_q;
   statetype_t state_d;
   ctrl_t      ctrl;
   logic       take;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECUTER;
               OP_I:         state_d = S_EXECUTEI;
               OP_BRANCH:    state_d = S_BRANCH;
               OP_JAL:       state_d = S_JAL;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_d = S_MEMWB;
         S_EXECUTER: state_d = S_ALUWB;
         S_EXECUTEI: state_d = S_ALUWB;
         S_JAL:      state_d = S_ALUWB;
         default:    state_d = S_FETCH;
      endcase
   end

   main_fsm_out_dec u_out_dec (
      .state_i (state_q),
      .ctrl_o  (ctrl)
   );

   // bne inverts the sense of the zero flag; all other funct3 compare as beq.
   assign take = ((BNE_EN != 0) && (funct3 == F3_BNE)) ? ~zero : zero;

   // Strobes are masked while reset is held; the mux selects keep FETCH values.
   assign IRWrite   = ctrl.irwrite  & ~reset;
   assign PCWrite   = (ctrl.pcupdate | (ctrl.branch & take)) & ~reset;
   assign MemWrite  = ctrl.memwrite & ~reset;
   assign RegWrite  = ctrl.regwrite & ~reset;
   assign AdrSrc    = ctrl.adrsrc;
   assign ResultSrc = ctrl.resultsrc;
   assign ALUSrcA   = ctrl.alusrca;
   assign ALUSrcB   = ctrl.alusrcb;
   assign ALUOp     = ctrl.aluop;
   assign state_o   = state_q;

endmodule
